// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state type, region constants and decode helper for the data memory controller
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RAM_ACC, PER_ACC, RESP} ctrl_state_e;

    localparam int REGION_RAM = 0;

    function automatic logic [31:0] region_idx(input logic [31:0] addr, input int addr_w, input int sel_w);
        return addr >> (addr_w - sel_w);
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: maps the top address bits onto RAM, a peripheral channel, or an unmapped region
module mem_region_decode
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SEL_W  = 1,
    parameter int NREG   = 2
) (
    input  logic [ADDR_W-1:0] daddr,
    output logic [SEL_W-1:0]  region,
    output logic              ram_sel,
    output logic [NREG-2:0]   per_onehot,
    output logic              unmapped
);

    assign region   = SEL_W'(region_idx(32'(daddr), ADDR_W, SEL_W));
    assign ram_sel  = int'(region) == REGION_RAM;
    assign unmapped = int'(region) >= NREG;

    for (genvar k = 0; k < NREG - 1; k++) begin : g_sel
        assign per_onehot[k] = int'(region) == k + 1;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: core load/store port to RAM and peripheral channels with wait states and error response
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int PER_W    = 16,
    parameter int NREG     = 2,
    parameter int SEL_W    = 1,
    parameter int RAM_LAT  = 1,
    parameter int PER_WAIT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_req,
    input  logic                    d_rw,
    input  logic [ADDR_W-1:0]       daddr,
    input  logic [DATA_W-1:0]       ddata_w,
    output logic [DATA_W-1:0]       ddata_r,
    output logic                    d_ack,
    output logic                    d_err,
    output logic                    d_busy,
    output logic                    mem0_ena,
    output logic                    mem0_rw,
    output logic [ADDR_W-SEL_W-1:0] mem0_addr,
    output logic [DATA_W-1:0]       mem0_dw,
    input  logic [DATA_W-1:0]       mem0_dr,
    output logic [NREG-2:0]         mem1_ena,
    output logic                    mem1_rw,
    output logic [ADDR_W-SEL_W-1:0] mem1_addr,
    output logic [PER_W-1:0]        mem1_dout,
    input  logic [PER_W-1:0]        mem1_din
);

    localparam int OW   = ADDR_W - SEL_W;
    localparam int MAXL = RAM_LAT > PER_WAIT + 1 ? RAM_LAT : PER_WAIT + 1;
    localparam int CW   = $clog2(MAXL + 1);

    ctrl_state_e       st;
    logic [CW-1:0]     cnt;
    logic [OW-1:0]     cap_addr;
    logic [DATA_W-1:0] cap_wd;
    logic [NREG-2:0]   cap_sel;
    logic              cap_rw;
    logic              err;
    logic [SEL_W-1:0]  region;
    logic              ram_sel;
    logic [NREG-2:0]   per_onehot;
    logic              unmapped;
    logic              last;
    logic              per_on;

    mem_region_decode #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .NREG(NREG)) u_dec (
        .daddr      (daddr),
        .region     (region),
        .ram_sel    (ram_sel),
        .per_onehot (per_onehot),
        .unmapped   (unmapped)
    );

    assign last = cnt == CW'(1);

    // Capture on acceptance, count wait states, register read data on the final access edge
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_wd   <= '0;
            cap_sel  <= '0;
            cap_rw   <= 1'b0;
            err      <= 1'b0;
            ddata_r  <= '0;
        end else begin
            case (st)
                IDLE: if (d_req) begin
                    cap_addr <= daddr[OW-1:0];
                    cap_wd   <= ddata_w;
                    cap_rw   <= d_rw;
                    cap_sel  <= ram_sel ? '0 : per_onehot;
                    err      <= unmapped;
                    cnt      <= ram_sel ? CW'(RAM_LAT) : CW'(PER_WAIT + 1);
                    st       <= unmapped ? RESP : (int'(region) == REGION_RAM) ? RAM_ACC : PER_ACC;
                end
                RAM_ACC, PER_ACC: if (last) begin
                    st <= RESP;
                    if (!cap_rw) ddata_r <= (st == RAM_ACC) ? mem0_dr : DATA_W'(mem1_din);
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    assign per_on    = st == PER_ACC;
    assign d_ack     = st == RESP;
    assign d_err     = d_ack & err;
    assign d_busy    = st != IDLE;
    assign mem0_ena  = st == RAM_ACC;
    assign mem0_rw   = mem0_ena & cap_rw;
    assign mem0_addr = mem0_ena ? cap_addr : '0;
    assign mem0_dw   = mem0_ena ? cap_wd : '0;
    assign mem1_ena  = per_on ? cap_sel : '0;
    assign mem1_rw   = per_on & cap_rw;
    assign mem1_addr = per_on ? cap_addr : '0;
    assign mem1_dout = per_on ? cap_wd[PER_W-1:0] : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: table-driven transactions plus corner-case sequences for data_mem_ctrl
module tb_data_mem_ctrl;

    typedef struct {
        bit          dut;
        bit          rw;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] m0;
        logic [15:0] m1;
        int          lat;
        logic [31:0] rd;
        bit          err;
        int          n0;
        int          n1;
        logic [1:0]  sel;
    } vec_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        d_req = 0;
    logic        req3 = 0;
    logic        d_rw = 0;
    logic [9:0]  daddr = '0;
    logic [31:0] ddata_w = '0;
    logic [31:0] mem0_dr = '0;
    logic [15:0] mem1_din = '0;
    logic        use3 = 0;

    logic [31:0] rd_a, rd_b, dw_a, dw_b;
    logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;
    logic        e0_a, e0_b, rw0_a, rw0_b, rw1_a, rw1_b;
    logic [8:0]  a0_a, a1_a;
    logic [7:0]  a0_b, a1_b;
    logic        e1_a;
    logic [1:0]  e1_b;
    logic [15:0] do_a, do_b;

    logic [31:0] o_rd, o_dw0;
    logic        o_ack, o_err, o_e0, o_rw0, o_rw1;
    logic [8:0]  o_a0, o_a1;
    logic [1:0]  o_e1;
    logic [15:0] o_do1;

    int passed = 0;
    int total = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    data_mem_ctrl u_dut (
        .clk(clk), .reset(reset), .d_req(d_req), .d_rw(d_rw), .daddr(daddr), .ddata_w(ddata_w),
        .ddata_r(rd_a), .d_ack(ack_a), .d_err(err_a), .d_busy(busy_a),
        .mem0_ena(e0_a), .mem0_rw(rw0_a), .mem0_addr(a0_a), .mem0_dw(dw_a), .mem0_dr(mem0_dr),
        .mem1_ena(e1_a), .mem1_rw(rw1_a), .mem1_addr(a1_a), .mem1_dout(do_a), .mem1_din(mem1_din)
    );

    data_mem_ctrl #(.NREG(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .d_req(req3), .d_rw(d_rw), .daddr(daddr), .ddata_w(ddata_w),
        .ddata_r(rd_b), .d_ack(ack_b), .d_err(err_b), .d_busy(busy_b),
        .mem0_ena(e0_b), .mem0_rw(rw0_b), .mem0_addr(a0_b), .mem0_dw(dw_b), .mem0_dr(mem0_dr),
        .mem1_ena(e1_b), .mem1_rw(rw1_b), .mem1_addr(a1_b), .mem1_dout(do_b), .mem1_din(mem1_din)
    );

    assign o_rd  = use3 ? rd_b : rd_a;
    assign o_ack = use3 ? ack_b : ack_a;
    assign o_err = use3 ? err_b : err_a;
    assign o_e0  = use3 ? e0_b : e0_a;
    assign o_rw0 = use3 ? rw0_b : rw0_a;
    assign o_a0  = use3 ? {1'b0, a0_b} : a0_a;
    assign o_dw0 = use3 ? dw_b : dw_a;
    assign o_e1  = use3 ? e1_b : {1'b0, e1_a};
    assign o_rw1 = use3 ? rw1_b : rw1_a;
    assign o_a1  = use3 ? {1'b0, a1_b} : a1_a;
    assign o_do1 = use3 ? do_b : do_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run(input int i, input vec_t v);
        int c0 = 0;
        int c1 = 0;
        int lat = 0;
        bit bad = 0;
        logic [31:0] rd_s = 'x;
        logic err_s = 1'bx;
        logic [8:0] off;
        off = v.dut ? {1'b0, v.addr[7:0]} : v.addr[8:0];
        @(negedge clk);
        use3 = v.dut;
        d_rw = v.rw;
        daddr = v.addr;
        ddata_w = v.wd;
        mem0_dr = v.m0;
        mem1_din = v.m1;
        if (v.dut) req3 = 1; else d_req = 1;
        @(posedge clk);
        #1;
        d_req = 0;
        req3 = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (o_e0) begin
                c0++;
                if (o_rw0 !== v.rw || o_a0 !== off || o_dw0 !== v.wd) bad = 1;
            end else if (o_rw0 !== 1'b0 || o_a0 !== '0 || o_dw0 !== '0) bad = 1;
            if (o_e1 !== 2'b00) begin
                c1++;
                if (o_e1 !== v.sel || o_rw1 !== v.rw || o_a1 !== off || o_do1 !== v.wd[15:0] || o_e0) bad = 1;
            end else if (o_rw1 !== 1'b0 || o_a1 !== '0 || o_do1 !== '0) bad = 1;
            if (o_ack) begin
                lat = c;
                rd_s = o_rd;
                err_s = o_err;
            end
        end
        chk($sformatf("v%0d_ack_latency", i), lat, v.lat);
        chk($sformatf("v%0d_ddata_r", i), rd_s, v.rd);
        chk($sformatf("v%0d_d_err", i), {31'b0, err_s}, {31'b0, v.err});
        chk($sformatf("v%0d_mem0_cycles", i), c0, v.n0);
        chk($sformatf("v%0d_mem1_cycles", i), c1, v.n1);
        chk($sformatf("v%0d_target_signals", i), {31'b0, bad}, 32'd0);
    endtask

    initial begin
        int acks;
        bit badseq;
        vec_t v;
        vecs[0] = '{0, 0, 10'h004, 32'h0, 32'hDEADBEEF, 16'h0, 2, 32'hDEADBEEF, 0, 1, 0, 2'b00};
        vecs[1] = '{0, 1, 10'h204, 32'h1234ABCD, 32'h0, 16'h0, 4, 32'hDEADBEEF, 0, 0, 3, 2'b01};
        vecs[2] = '{0, 0, 10'h204, 32'h0, 32'h0, 16'h8001, 4, 32'h00008001, 0, 0, 3, 2'b01};
        vecs[3] = '{0, 1, 10'h010, 32'h55AA55AA, 32'h11111111, 16'h0, 2, 32'h00008001, 0, 1, 0, 2'b00};
        vecs[4] = '{0, 0, 10'h1FC, 32'h0, 32'h0, 16'h7777, 2, 32'h0, 0, 1, 0, 2'b00};
        vecs[5] = '{0, 0, 10'h3FE, 32'h0, 32'h12345678, 16'hFFFF, 4, 32'h0000FFFF, 0, 0, 3, 2'b01};
        vecs[6] = '{1, 0, 10'h0A0, 32'h0, 32'hCAFEF00D, 16'h0, 2, 32'hCAFEF00D, 0, 1, 0, 2'b00};
        vecs[7] = '{1, 0, 10'h204, 32'h0, 32'h0, 16'h8001, 4, 32'h00008001, 0, 0, 3, 2'b10};
        vecs[8] = '{1, 1, 10'h1FC, 32'hA5A55A5A, 32'h0, 16'h0, 4, 32'h00008001, 0, 0, 3, 2'b01};
        vecs[9] = '{1, 0, 10'h304, 32'h0, 32'hFFFFFFFF, 16'hFFFF, 1, 32'h00008001, 1, 0, 0, 2'b00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", {31'b0, ack_a}, 0);
        chk("reset_busy", {30'b0, busy_a, busy_b}, 0);
        chk("reset_ddata_r", rd_a, 0);
        chk("reset_enables", {28'b0, e0_a, e1_a, e1_b}, 0);
        reset = 0;

        for (int i = 0; i < 10; i++) run(i, vecs[i]);
        use3 = 0;

        @(negedge clk);
        d_rw = 0;
        daddr = 10'h008;
        mem0_dr = 32'h0BADF00D;
        d_req = 1;
        acks = 0;
        badseq = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack_a) acks++;
            if (ack_a !== (i % 3 == 2)) badseq = 1;
        end
        d_req = 0;
        chk("held_req_ack_count", acks, 4);
        chk("held_req_ack_spacing", {31'b0, badseq}, 0);
        chk("held_req_rdata", rd_a, 32'h0BADF00D);

        @(negedge clk);
        daddr = 10'h210;
        mem1_din = 16'h2222;
        d_req = 1;
        @(posedge clk);
        #1;
        d_req = 0;
        @(negedge clk);
        d_req = 1;
        @(posedge clk);
        #1;
        d_req = 0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        chk("busy_req_dropped_acks", acks, 1);
        chk("busy_req_idle_after", {31'b0, busy_a}, 0);

        @(negedge clk);
        daddr = 10'h204;
        mem1_din = 16'h1111;
        d_req = 1;
        @(posedge clk);
        #1;
        d_req = 0;
        @(negedge clk);
        chk("midrst_in_per_acc", {31'b0, e1_a}, 1);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("midrst_enables_off", {30'b0, e0_a, e1_a}, 0);
        chk("midrst_idle", {31'b0, busy_a}, 0);
        chk("midrst_ddata_r", rd_a, 0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        chk("midrst_no_ack", acks, 0);
        v = '{0, 0, 10'h206, 32'h0, 32'h0, 16'h0F0F, 4, 32'h00000F0F, 0, 0, 3, 2'b01};
        run(10, v);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
